// File: rtl/adc_pkg.sv
// Shared ADC definitions: channel count, sample width, averaging FSM encoding
// and the helper that maps a channel index onto its packed bit range.
package adc_pkg;

  localparam int unsigned NUM_ADC_CH = 4;
  localparam int unsigned ADC_DW     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DUMP = 2'd2
  } adc_state_e;

  // Lowest bit of channel idx inside a packed {chN..ch1} vector of dw-bit samples
  function automatic int unsigned ch_lo(input int unsigned idx, input int unsigned dw);
    return idx * dw;
  endfunction

endpackage

// File: rtl/adc_avg_filter_if.sv
// Sample/result bus between the LTC1864 reader, the averaging filter and the
// register map; master drives conversion sets and clear, slave returns averages.
interface adc_avg_filter_if
  import adc_pkg::*;
#(
  parameter int unsigned DW = ADC_DW
) ();

  logic                     in_valid;
  logic [NUM_ADC_CH*DW-1:0] in_data;
  logic                     clear;
  logic [NUM_ADC_CH*DW-1:0] out_data;
  logic                     out_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output in_valid, in_data, clear,
    input  out_data, out_valid, busy, overrun
  );

  modport slave (
    input  in_valid, in_data, clear,
    output out_data, out_valid, busy, overrun
  );

endinterface

// File: rtl/adc_avg_filter.sv
// Per-channel boxcar average over 2^LOG2_WIN conversion sets, using one shared
// adder stepped across the four channels by a small IDLE/ACC/DUMP FSM.
module adc_avg_filter
  import adc_pkg::*;
#(
  parameter int unsigned LOG2_WIN = 4,
  parameter int unsigned DW       = ADC_DW
) (
  input  logic              clk,
  input  logic              reset,
  adc_avg_filter_if.slave   bus
);

  localparam int unsigned AW  = DW + LOG2_WIN;
  localparam int unsigned CW  = (LOG2_WIN == 0) ? 1 : LOG2_WIN;
  localparam int unsigned CHW = $clog2(NUM_ADC_CH);
  localparam logic [CW-1:0]  WIN_MAX = CW'((32'd1 << LOG2_WIN) - 32'd1);
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_ADC_CH - 1);

  adc_state_e               state_r;
  adc_state_e               next_state_s;
  logic [CHW-1:0]           ch_r;
  logic [CW-1:0]            cnt_r;
  logic [NUM_ADC_CH*DW-1:0] cap_r;
  logic [NUM_ADC_CH*DW-1:0] out_data_r;
  logic [AW-1:0]            acc_r [NUM_ADC_CH];
  logic [DW-1:0]            avg_s [NUM_ADC_CH];
  logic [DW-1:0]            sample_s;
  logic                     out_valid_r;
  logic                     busy_r;
  logic                     overrun_r;
  logic                     capture_s;
  logic                     acc_en_s;
  logic                     dump_s;
  logic                     ovr_set_s;
  logic                     win_done_s;
  logic                     last_ch_s;

  // With LOG2_WIN = 0 the counter is pinned at 0 == WIN_MAX, so every set completes a window
  assign win_done_s = (cnt_r == WIN_MAX);
  assign last_ch_s  = (ch_r == LAST_CH);
  assign sample_s   = cap_r[ch_lo(32'(ch_r), DW) +: DW];

  // Truncating divide of each accumulator by the window length
  always_comb begin
    for (int unsigned i = 0; i < NUM_ADC_CH; i++) begin
      avg_s[i] = DW'(acc_r[i] >> LOG2_WIN);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and datapath strobes; clear overrides everything
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    acc_en_s     = 1'b0;
    dump_s       = 1'b0;
    ovr_set_s    = 1'b0;
    if (bus.clear) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            capture_s    = 1'b1;
            next_state_s = ACC;
          end else begin
            next_state_s = IDLE;
          end
        end
        ACC: begin
          acc_en_s  = 1'b1;
          ovr_set_s = bus.in_valid;
          if (last_ch_s) begin
            if (win_done_s) begin
              next_state_s = DUMP;
            end else begin
              next_state_s = IDLE;
            end
          end else begin
            next_state_s = ACC;
          end
        end
        DUMP: begin
          dump_s       = 1'b1;
          ovr_set_s    = bus.in_valid;
          next_state_s = IDLE;
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

  // Capture, shared-adder accumulation, window dump and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_r        <= '0;
      cnt_r       <= '0;
      cap_r       <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      for (int unsigned i = 0; i < NUM_ADC_CH; i++) begin
        acc_r[i] <= '0;
      end
    end else if (bus.clear) begin
      // out_data deliberately keeps the last published average
      ch_r        <= '0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      for (int unsigned i = 0; i < NUM_ADC_CH; i++) begin
        acc_r[i] <= '0;
      end
    end else begin
      out_valid_r <= dump_s;
      busy_r      <= (next_state_s != IDLE);
      if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end
      if (capture_s) begin
        cap_r <= bus.in_data;
        ch_r  <= '0;
      end
      if (acc_en_s) begin
        acc_r[ch_r] <= acc_r[ch_r] + AW'(sample_s);
        ch_r        <= ch_r + CHW'(1);
        if (last_ch_s) begin
          cnt_r <= win_done_s ? '0 : (cnt_r + CW'(1));
        end
      end
      if (dump_s) begin
        for (int unsigned i = 0; i < NUM_ADC_CH; i++) begin
          out_data_r[ch_lo(i, DW) +: DW] <= avg_s[i];
          acc_r[i]                       <= '0;
        end
      end
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Bench for adc_avg_filter: a window-4 and a pass-through instance share one
// stimulus stream and are checked every cycle against a set-level average model.
module tb_adc_avg_filter;

  logic        clk;
  logic        rst_n;
  logic        tb_in_valid;
  logic [63:0] tb_in_data;
  logic        tb_clear;

  int n_cmp;
  int n_err;
  int pulses2;
  int pulses0;

  adc_avg_filter_if #(.DW(16)) bus2 ();
  adc_avg_filter_if #(.DW(16)) bus0 ();

  assign bus2.in_valid = tb_in_valid;
  assign bus2.in_data  = tb_in_data;
  assign bus2.clear    = tb_clear;
  assign bus0.in_valid = tb_in_valid;
  assign bus0.in_data  = tb_in_data;
  assign bus0.clear    = tb_clear;

  adc_avg_filter #(.LOG2_WIN(2), .DW(16)) u_dut2 (.clk(clk), .reset(rst_n), .bus(bus2));
  adc_avg_filter #(.LOG2_WIN(0), .DW(16)) u_dut0 (.clk(clk), .reset(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (index 0: window 4, index 1: window 1)
  int unsigned sums [2][4];
  int          cnt [2];
  longint      free_at [2];
  longint      dump_at [2];
  logic [15:0] dvals [2][4];
  logic [63:0] exp_data [2];
  logic        exp_valid [2];
  logic        exp_busy [2];
  logic        exp_ovr [2];
  longint      cyc;

  function automatic int lw(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) sums[k][c] = 0;
      cnt[k] = 0; free_at[k] = 0; dump_at[k] = -1;
      exp_data[k] = 64'd0; exp_valid[k] = 1'b0; exp_busy[k] = 1'b0; exp_ovr[k] = 1'b0;
    end
  endtask

  task automatic step_model(input int k);
    exp_valid[k] = 1'b0;
    if (tb_clear) begin
      for (int c = 0; c < 4; c++) sums[k][c] = 0;
      cnt[k] = 0; exp_ovr[k] = 1'b0; dump_at[k] = -1; free_at[k] = cyc + 1;
    end else begin
      if (dump_at[k] == cyc) begin
        for (int c = 0; c < 4; c++) exp_data[k][c*16 +: 16] = dvals[k][c];
        exp_valid[k] = 1'b1;
        dump_at[k] = -1;
      end
      if (tb_in_valid) begin
        if (cyc >= free_at[k]) begin
          for (int c = 0; c < 4; c++) sums[k][c] += int'(tb_in_data[c*16 +: 16]);
          cnt[k] = (cnt[k] + 1) % (1 << lw(k));
          if (cnt[k] == 0) begin
            for (int c = 0; c < 4; c++) begin
              dvals[k][c] = 16'(sums[k][c] >> lw(k));
              sums[k][c] = 0;
            end
            dump_at[k] = cyc + 5;
            free_at[k] = cyc + 6;
          end else begin
            free_at[k] = cyc + 5;
          end
        end else begin
          exp_ovr[k] = 1'b1;
        end
      end
    end
    exp_busy[k] = (cyc <= free_at[k] - 2);
  endtask

  initial begin
    cyc = 0;
    reset_model();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        reset_model();
      end else begin
        cyc++;
        step_model(0);
        step_model(1);
      end
    end
  end

  // ---------------- checking
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic cmp_one(input int k, input string tag, input logic [63:0] d,
                         input logic v, input logic b, input logic o);
    chk({tag, " out_data"}, d, exp_data[k]);
    chk({tag, " out_valid"}, 64'(v), 64'(exp_valid[k]));
    chk({tag, " busy"}, 64'(b), 64'(exp_busy[k]));
    chk({tag, " overrun"}, 64'(o), 64'(exp_ovr[k]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_one(0, "win4", bus2.out_data, bus2.out_valid, bus2.busy, bus2.overrun);
      cmp_one(1, "win1", bus0.out_data, bus0.out_valid, bus0.busy, bus0.overrun);
    end
  end

  initial begin
    pulses2 = 0;
    pulses0 = 0;
    forever begin
      @(negedge clk);
      if (bus2.out_valid) pulses2++;
      if (bus0.out_valid) pulses0++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus
  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic strobe(input logic [63:0] d, input logic clr);
    tb_in_valid = 1'b1; tb_in_data = d; tb_clear = clr;
    gap(1);
    tb_in_valid = 1'b0; tb_clear = 1'b0;
  endtask

  task automatic pulse_clear();
    tb_clear = 1'b1;
    gap(1);
    tb_clear = 1'b0;
  endtask

  task automatic at_t5();
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
  endtask

  function automatic logic [63:0] ramp(input int k);
    logic [63:0] r;
    for (int c = 0; c < 4; c++) r[c*16 +: 16] = 16'(c * 16'h1000 + k * 16'h0011);
    return r;
  endfunction

  int p;
  logic [63:0] d;

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; tb_in_valid = 1'b0; tb_in_data = 64'd0; tb_clear = 1'b0;
    gap(3);
    rst_n = 1'b1;
    gap(2);
    chk("reset out_data", bus2.out_data, 64'd0);
    chk("reset flags", {61'd0, bus2.out_valid, bus2.busy, bus2.overrun}, 64'd0);

    // reset in the middle of an accumulation leaves no partial sum
    strobe(64'h7777_6666_5555_4444, 1'b0);
    gap(1);
    rst_n = 1'b0;
    gap(2);
    rst_n = 1'b1;
    gap(2);
    p = pulses2;
    for (int i = 0; i < 4; i++) begin
      strobe({4{16'h0100}}, 1'b0);
      if (i < 3) gap(7); else at_t5();
    end
    chk("reset-mid-acc mean", bus2.out_data, {4{16'h0100}});
    chk("reset-mid-acc pulses", 64'(pulses2 - p), 64'd1);
    gap(4);

    // averaging with truncation, latency 5 after the window-completing set
    p = pulses2;
    for (int i = 0; i < 4; i++) begin
      strobe({16'hFFFF, 16'h8000, 16'h0003, (i == 0) ? 16'h0001 : 16'h0002}, 1'b0);
      if (i < 3) gap(7);
    end
    chk("no pulse sets 1-3", 64'(pulses2 - p), 64'd0);
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    chk("valid not at t+4", 64'(bus2.out_valid), 64'd0);
    @(negedge clk); #1;
    chk("valid at t+5", 64'(bus2.out_valid), 64'd1);
    chk("trunc mean", bus2.out_data, {16'hFFFF, 16'h8000, 16'h0003, 16'h0001});
    gap(4);

    // overrun: second strobe 3 cycles later is dropped, flag is sticky
    strobe({4{16'h0010}}, 1'b0);
    gap(2);
    strobe({4{16'h0AAA}}, 1'b0);
    gap(10);
    chk("overrun set", 64'(bus2.overrun), 64'd1);
    gap(5);
    chk("overrun sticky", 64'(bus2.overrun), 64'd1);
    pulse_clear();
    @(negedge clk); #1;
    chk("overrun cleared", 64'(bus2.overrun), 64'd0);
    gap(2);
    for (int i = 0; i < 4; i++) begin
      strobe({4{16'h0010}}, 1'b0);
      if (i < 3) gap(7); else at_t5();
    end
    chk("post-clear mean", bus2.out_data, {4{16'h0010}});
    gap(4);

    // clear coincident with the window-completing strobe wins
    p = pulses2;
    for (int i = 0; i < 4; i++) begin
      strobe({4{16'h0777}}, (i == 3) ? 1'b1 : 1'b0);
      gap(7);
    end
    chk("clear: no pulse", 64'(pulses2 - p), 64'd0);
    chk("clear: data held", bus2.out_data, {4{16'h0010}});
    chk("clear: overrun", 64'(bus2.overrun), 64'd0);
    for (int i = 0; i < 4; i++) begin
      strobe({4{16'h0020}}, 1'b0);
      if (i < 3) gap(7); else at_t5();
    end
    chk("after clear mean", bus2.out_data, {4{16'h0020}});
    gap(10);

    // pass-through instance: busy exactly t+1..t+5, result at t+5
    @(negedge clk); #1;
    chk("pt busy before", 64'(bus0.busy), 64'd0);
    strobe(64'hDEF0_9ABC_5678_1234, 1'b0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk); #1;
      chk($sformatf("pt busy %0d", j), 64'(bus0.busy), (j < 5) ? 64'd1 : 64'd0);
      chk($sformatf("pt valid %0d", j), 64'(bus0.out_valid), (j == 5) ? 64'd1 : 64'd0);
    end
    chk("pt data", bus0.out_data, 64'hDEF0_9ABC_5678_1234);
    gap(4);

    // back-to-back sets at minimum spacing with a ramp
    pulse_clear();
    gap(2);
    p = pulses2;
    for (int k = 0; k < 8; k++) begin
      strobe(ramp(k), 1'b0);
      if (k == 3) begin
        at_t5();
        chk("b2b mean 1", bus2.out_data, 64'h3019_2019_1019_0019);
      end else if (k == 7) begin
        at_t5();
        chk("b2b mean 2", bus2.out_data, 64'h305D_205D_105D_005D);
      end else begin
        gap(5);
      end
    end
    chk("b2b pulses", 64'(pulses2 - p), 64'd2);
    chk("b2b overrun", 64'(bus2.overrun), 64'd0);
    gap(3);

    // randomized traffic, clears and occasional resets
    for (int i = 0; i < 300; i++) begin
      d = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        gap(1);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 5) != 0) strobe(d, ($urandom_range(0, 19) == 0));
      else if ($urandom_range(0, 3) == 0) pulse_clear();
      gap($urandom_range(0, 8));
    end
    gap(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
